// File: rtl/sixteenbit_nibble_sub.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sixteenbit_nibble_sub : digit-serial unsigned subtractor, X - Y - Bin,   |
// |                         one DIGIT-bit slice per clock, LSB digit first   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module sixteenbit_nibble_sub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(NDIG - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_res;
  logic             r_c;
  logic [CW-1:0]    r_cnt;

  logic [DIGIT:0]   w_sum;
  logic [WIDTH-1:0] w_res_next;

  // Subtraction as X + ~Y + c, where c is the inverted borrow carried between digits.
  always_comb begin
    w_sum      = {1'b0, r_x[DIGIT-1:0]} + {1'b0, ~r_y[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_c};
    w_res_next = {w_sum[DIGIT-1:0], r_res[WIDTH-1:DIGIT]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_res   <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      diff    <= '0;
      bout    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            r_x     <= x;
            r_y     <= y;
            r_c     <= ~bin;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= S_RUN;
          end else begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_x   <= r_x >> DIGIT;
          r_y   <= r_y >> DIGIT;
          r_c   <= w_sum[DIGIT];
          r_res <= w_res_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == C_LAST) begin
            diff    <= w_res_next;
            bout    <= ~w_sum[DIGIT];
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_DONE;
          end
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
